// File: rtl/dec_pkg.sv
// Shared types and helpers for the 4-to-16 handshake decoder.
package dec_pkg;

  localparam int CODE_W   = 4;
  localparam int ONEHOT_W = 2 ** CODE_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } dec_state_e;

  // Disabled decodes still produce a word, just an all-zero one.
  function automatic logic [ONEHOT_W-1:0] onehot_f(input logic [CODE_W-1:0] code,
                                                    input logic              en);
    onehot_f = en ? (ONEHOT_W'(1) << code) : '0;
  endfunction

endpackage

// File: rtl/decoder_4to16_hs_if.sv
// Valid/ready bus for the decoder: binary code in, one-hot word out.
interface decoder_4to16_hs_if #(
  parameter int CODE_W = dec_pkg::CODE_W
);
  localparam int ONEHOT_W = 2 ** CODE_W;

  logic                in_valid;
  logic                in_ready;
  logic [CODE_W-1:0]   in_code;
  logic                in_en;
  logic                out_valid;
  logic                out_ready;
  logic [ONEHOT_W-1:0] out_onehot;

  modport slave (
    input  in_valid, in_code, in_en, out_ready,
    output in_ready, out_valid, out_onehot
  );

  modport master (
    output in_valid, in_code, in_en, out_ready,
    input  in_ready, out_valid, out_onehot
  );

endinterface

// File: rtl/dec_skid_buf.sv
// Generic two-entry skid buffer; in_ready comes straight from a flop so the
// upstream side never sees a combinational path from out_ready.
module dec_skid_buf
  import dec_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  dec_state_e   state_reg, state_next;
  logic [W-1:0] main_reg, main_next;
  logic [W-1:0] skid_reg, skid_next;
  logic         in_ready_reg;
  logic         push, pop;

  assign push      = in_valid && in_ready_reg;
  assign pop       = (state_reg != EMPTY) && out_ready;
  assign in_ready  = in_ready_reg;
  assign out_valid = (state_reg != EMPTY);
  assign out_data  = main_reg;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      EMPTY: begin
        if (push) begin
          main_next  = in_data;
          state_next = FULL;
        end
      end
      FULL: begin
        if (push && pop) begin
          main_next = in_data;
        end else if (push) begin
          // Output stalled: park the newer word behind the held one.
          skid_next  = in_data;
          state_next = SKID;
        end else if (pop) begin
          state_next = EMPTY;
        end
      end
      SKID: begin
        if (pop) begin
          main_next  = skid_reg;
          state_next = FULL;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      main_reg     <= '0;
      skid_reg     <= '0;
      in_ready_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      main_reg     <= main_next;
      skid_reg     <= skid_next;
      in_ready_reg <= (state_next != SKID);
    end
  end

endmodule

// File: rtl/decoder_4to16_hs.sv
// Registered 4-to-16 one-hot decoder with valid/ready on both sides and a
// saturating accepted-transfer counter. Define DEC_SKID_EN for a skid buffer.
module decoder_4to16_hs
  import dec_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  decoder_4to16_hs_if.slave  bus,
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   xfer_cnt
);

  logic [ONEHOT_W-1:0] dec_word;
  logic                in_xfer;
  logic [CNT_W-1:0]    xfer_cnt_reg;

  assign dec_word = onehot_f(bus.in_code, bus.in_en);
  assign in_xfer  = bus.in_valid && bus.in_ready;

`ifdef DEC_SKID_EN
  dec_skid_buf #(
    .W (ONEHOT_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (bus.in_valid),
    .in_ready  (bus.in_ready),
    .in_data   (dec_word),
    .out_valid (bus.out_valid),
    .out_ready (bus.out_ready),
    .out_data  (bus.out_onehot)
  );
`else
  dec_state_e          state_reg, state_next;
  logic [ONEHOT_W-1:0] word_reg, word_next;
  logic                out_xfer;

  assign out_xfer       = bus.out_valid && bus.out_ready;
  assign bus.out_valid  = (state_reg == FULL);
  assign bus.out_onehot = word_reg;
  // A full register can still take a word on the cycle it is being drained.
  assign bus.in_ready   = (state_reg != FULL) || bus.out_ready;

  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    case (state_reg)
      EMPTY: begin
        if (in_xfer) begin
          word_next  = dec_word;
          state_next = FULL;
        end
      end
      FULL: begin
        if (in_xfer) begin
          word_next = dec_word;
        end else if (out_xfer) begin
          state_next = EMPTY;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      word_reg  <= '0;
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt_reg <= '0;
    end else if (cnt_clr) begin
      xfer_cnt_reg <= '0;
    end else if (in_xfer && (xfer_cnt_reg != '1)) begin
      xfer_cnt_reg <= xfer_cnt_reg + 1'b1;
    end
  end

  assign xfer_cnt = xfer_cnt_reg;

endmodule

// File: tb/tb_decoder_4to16_hs.sv
// Directed bench for decoder_4to16_hs: vector table plus backpressure,
// counter saturation/clear and asynchronous reset sequences.
module tb_decoder_4to16_hs;

  logic       clk;
  logic       rst_n;
  logic       cnt_clr;
  logic [7:0] xfer_cnt;

  decoder_4to16_hs_if #(.CODE_W(4)) bus ();

  decoder_4to16_hs #(
    .CNT_W (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .cnt_clr  (cnt_clr),
    .xfer_cnt (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  code;
    logic        en;
    logic [15:0] exp;
  } vec_t;

  vec_t        vecs [19];
  logic [15:0] q [$];
  int          cnt;
  int          checks;
  int          errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the scoreboard tracks words held by the DUT.
  task automatic cycle(input logic v, input logic [3:0] code, input logic en,
                       input logic [15:0] word, input logic ordy, input logic clr,
                       output logic acc);
    logic exp_rdy;
    logic pop;
    bus.in_valid  = v;
    bus.in_code   = code;
    bus.in_en     = en;
    bus.out_ready = ordy;
    cnt_clr       = clr;
    #1;
`ifdef DEC_SKID_EN
    exp_rdy = (q.size() < 2);
`else
    exp_rdy = (q.size() == 0) || ordy;
`endif
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
    acc = v && exp_rdy;
    pop = (q.size() > 0) && ordy;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (acc) q.push_back(word);
    if (clr) cnt = 0;
    else if (acc && cnt != 255) cnt++;
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
    if (q.size() > 0) chk("out_onehot", {16'd0, bus.out_onehot}, {16'd0, q[0]});
    chk("xfer_cnt", {24'd0, xfer_cnt}, cnt);
  endtask

  initial begin
    logic acc;
    int   k;
    checks = 0;
    errors = 0;
    cnt    = 0;

    vecs[0] = '{4'hA, 1'b1, 16'h0400};
    vecs[1] = '{4'h0, 1'b1, 16'h0001};
    vecs[2] = '{4'h1, 1'b1, 16'h0002};
    vecs[3] = '{4'h2, 1'b1, 16'h0004};
    vecs[4] = '{4'h3, 1'b1, 16'h0008};
    vecs[5] = '{4'h4, 1'b1, 16'h0010};
    vecs[6] = '{4'h5, 1'b1, 16'h0020};
    vecs[7] = '{4'h6, 1'b1, 16'h0040};
    vecs[8] = '{4'h7, 1'b1, 16'h0080};
    vecs[9] = '{4'h8, 1'b1, 16'h0100};
    vecs[10] = '{4'h9, 1'b1, 16'h0200};
    vecs[11] = '{4'hA, 1'b1, 16'h0400};
    vecs[12] = '{4'hB, 1'b1, 16'h0800};
    vecs[13] = '{4'hC, 1'b1, 16'h1000};
    vecs[14] = '{4'hD, 1'b1, 16'h2000};
    vecs[15] = '{4'hE, 1'b1, 16'h4000};
    vecs[16] = '{4'hF, 1'b1, 16'h8000};
    vecs[17] = '{4'h3, 1'b0, 16'h0000};
    vecs[18] = '{4'hF, 1'b0, 16'h0000};

    rst_n         = 1'b0;
    cnt_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_code   = 4'h0;
    bus.in_en     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_onehot", {16'd0, bus.out_onehot}, 32'd0);
    chk("rst_xfer_cnt", {24'd0, xfer_cnt}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back vectors at full throughput.
    for (int i = 0; i < 19; i++) begin
      cycle(1'b1, vecs[i].code, vecs[i].en, vecs[i].exp, 1'b1, 1'b0, acc);
      chk("vec_onehot", {16'd0, bus.out_onehot}, {16'd0, vecs[i].exp});
      $display("vec %0d code=%h en=%0d onehot=%h cnt=%0d",
               i, vecs[i].code, vecs[i].en, bus.out_onehot, xfer_cnt);
    end
    chk("vec_cnt", {24'd0, xfer_cnt}, 32'd19);
    cycle(1'b0, 4'h0, 1'b0, 16'h0, 1'b1, 1'b0, acc);

    // Backpressure: consumer stalls five cycles while the producer keeps offering.
    k = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 4'(5 + k), 1'b1, 16'h0001 << (5 + k), 1'b0, 1'b0, acc);
      if (acc) k++;
    end
`ifdef DEC_SKID_EN
    chk("bp_accepted", k, 32'd2);
`else
    chk("bp_accepted", k, 32'd1);
`endif
    chk("bp_held", {16'd0, bus.out_onehot}, 32'h0020);
    for (int i = 0; i < 6 && q.size() > 0; i++) begin
      cycle(1'b0, 4'h0, 1'b0, 16'h0, 1'b1, 1'b0, acc);
      $display("drain word=%h valid=%0d", bus.out_onehot, bus.out_valid);
    end
    cycle(1'b0, 4'h0, 1'b0, 16'h0, 1'b1, 1'b0, acc);

    // Counter saturation then clear coincident with a transfer.
    for (int i = 0; i < 260; i++) begin
      cycle(1'b1, 4'(i % 16), 1'b1, 16'h0001 << (i % 16), 1'b1, 1'b0, acc);
    end
    chk("cnt_sat", {24'd0, xfer_cnt}, 32'd255);
    cycle(1'b1, 4'h2, 1'b1, 16'h0004, 1'b1, 1'b1, acc);
    chk("cnt_clr", {24'd0, xfer_cnt}, 32'd0);
    cycle(1'b1, 4'h9, 1'b1, 16'h0200, 1'b1, 1'b0, acc);
    chk("cnt_after_clr", {24'd0, xfer_cnt}, 32'd1);

    // Asynchronous reset in the middle of a cycle with a word held.
    cycle(1'b1, 4'hC, 1'b1, 16'h1000, 1'b0, 1'b0, acc);
    chk("pre_rst_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("async_out_onehot", {16'd0, bus.out_onehot}, 32'd0);
    chk("async_xfer_cnt", {24'd0, xfer_cnt}, 32'd0);
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    cnt = 0;
    #1;
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    cycle(1'b1, 4'h7, 1'b1, 16'h0080, 1'b1, 1'b0, acc);
    chk("post_rst_word", {16'd0, bus.out_onehot}, 32'h0080);
    chk("post_rst_cnt", {24'd0, xfer_cnt}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decoder_4to16_hs.md
# decoder_4to16_hs

Registered 4-to-16 one-hot decoder with a valid/ready handshake on both sides, the inverse of the team's 16-to-4 encoder. It accepts a 4-bit code plus an enable qualifier and produces a 16-bit one-hot (or all-zero, when disabled) word that is held stable until the consumer accepts it. It sits between control logic that emits binary select codes and downstream blocks that need one-hot strobes, such as bank selects or channel grants. An accepted-transfer counter is kept for debug.

## Interface
- CODE_W, 4: width of the input code; the one-hot width is 2**CODE_W.
- CNT_W, 8: width of the saturating accepted-transfer counter.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  input code valid.
- in_ready  out  1  block can accept the input this cycle.
- in_code  in  CODE_W  binary code to decode.
- in_en  in  1  1 = decode normally; 0 = emit an all-zero word (consumes a handshake slot).
- out_valid  out  1  out_onehot valid.
- out_ready  in  1  consumer accepts out_onehot.
- out_onehot  out  2**CODE_W  decoded word; bit in_code set when in_en=1.
- xfer_cnt  out  CNT_W  count of accepted input transfers, saturating at all-ones.
- cnt_clr  in  1  synchronous clear of xfer_cnt.

## Operation
- Input transfer occurs on a clk edge with in_valid && in_ready. Output transfer occurs with out_valid && out_ready.
- Decoding: out_onehot = in_en ? (1 << in_code) : 0. The word is computed at input acceptance and registered.
- Output stage states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1, word held.
  - SKID (only with DEC_SKID_EN): output full and one extra word buffered.
- Transitions without skid:
  - EMPTY→FULL on an input transfer.
  - FULL→FULL on simultaneous input and output transfers; the new word replaces the old.
  - FULL→EMPTY on an output transfer only.
- out_onehot and out_valid must not change while out_valid=1 && out_ready=0.
- xfer_cnt increments by 1 per input transfer and saturates at 2**CNT_W-1.
  - cnt_clr has priority over increment; xfer_cnt reads 0 on the next cycle.
- Reset (asynchronous, at any time, including mid-transfer):
  - out_valid=0, out_onehot=0, xfer_cnt=0, state EMPTY, buffered word discarded.
  - in_ready=1 once rst_n is deasserted.
- in_code and in_en are ignored when in_valid=0. No X is ever driven on out_onehot.

## Timing
- Latency is 1 cycle: an input accepted at edge N has out_valid=1 after edge N.
- Throughput is 1 word per cycle while out_ready=1.
- Without DEC_SKID_EN, in_ready = !out_valid || out_ready. This is a combinational path from out_ready.
- With DEC_SKID_EN, in_ready is a registered output equal to "skid slot empty".
  - Full throughput is sustained.
  - At most one extra word is absorbed after out_ready drops.
- xfer_cnt updates on the same edge as the input transfer.

## Configuration
- DEC_SKID_EN defined: a 2-entry skid buffer is included, and in_ready has no combinational dependence on out_ready.
  - When the output stalls, the following accepted word goes to the skid slot and in_ready drops on the next cycle.
  - When the output drains, the skid word moves to the output and in_ready rises.
  - Ordering is strictly preserved.
- DEC_SKID_EN undefined: single output register with combinational in_ready, as described above.

## Structure
- Package dec_pkg:
  - CODE_W default and ONEHOT_W = 2**CODE_W.
  - Function onehot_f(code, en) returning the decoded word.
  - Enum for output state: EMPTY, FULL, SKID.
- One sub-module, dec_skid_buf: a generic width-parameterised skid buffer, instantiated only under DEC_SKID_EN.
- The top level holds the decode, the state register and xfer_cnt.

## Test plan
- Reset then single transfer: in_code=4'hA, in_en=1, out_ready=1 → after one edge, out_valid=1 and out_onehot=16'h0400; xfer_cnt=1.
- Sweep codes 0..15 back-to-back with out_ready=1 → one word per cycle, out_onehot=1<<k in order, xfer_cnt=16.
- in_en=0 with in_code=4'h3 → out_onehot=16'h0000, out_valid=1, xfer_cnt increments.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 → output held stable.
  - Without DEC_SKID_EN, in_ready=0.
  - With DEC_SKID_EN, exactly one extra word is accepted and then in_ready=0.
  - After release, words emerge in order with none lost or duplicated.
- Counter: 260 transfers with CNT_W=8 → xfer_cnt=255. Assert cnt_clr together with a transfer → xfer_cnt=0 on the next cycle.
- Assert rst_n low mid-stream while out_valid=1 → out_valid=0, out_onehot=0 and xfer_cnt=0 immediately (asynchronous); in_ready=1 after release.
